mux_rr_sel: RTL and testbench

- Round-robin select sequencer; sits directly upstream of the 4:1 3-bit enable mux and drives its `se[1:0]` and `en`.
- Scans four channel request lines and grants one channel at a time for a programmable dwell.
- Inserts a one-cycle break-before-make gap, with `en` low, between grants.
- While `en` is low the downstream mux drives high-Z, so the gap guarantees no two channels overlap on the shared bus.

---
 rtl/mux_rr_sel.sv | 128 ++++++++++++
 tb/tb_mux_rr_sel.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_sel.sv
// Round-robin select sequencer driving se/en of a 4:1 enable mux.
// Grants one requesting channel at a time for DWELL cycles. A
// one-cycle gap with en low separates grants, so no two channels
// ever drive the shared bus together.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   req[3:0]    per-channel request lines
//   hold        freezes the dwell counter and extends the grant
//   se[1:0]     registered channel select
//   en          registered mux enable, high only while granting
//   grant_start one-cycle pulse in the first cycle of each grant
//   busy        high while granting or in the gap
module mux_rr_sel #(
    parameter int DWELL = 4,
    parameter int CW    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       hold,
    output logic [1:0] se,
    output logic       en,
    output logic       grant_start,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    se_q, se_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          en_q, en_d;
    logic          gs_q, gs_d;
    logic          busy_q, busy_d;

    logic          found;
    logic [1:0]    win;

    // Search starts one past the last-served channel and wraps.
    always_comb begin
        found = 1'b0;
        win   = 2'b00;
        for (int k = 1; k <= 4; k++) begin
            if (!found && req[ptr_q + 2'(k)]) begin
                found = 1'b1;
                win   = ptr_q + 2'(k);
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            se_q    <= 2'b00;
            ptr_q   <= 2'b11;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            gs_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            se_q    <= se_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            gs_q    <= gs_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        se_d    = se_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, GAP: begin
                if (found) begin
                    state_d = GRANT;
                    se_d    = win;
                    cnt_d   = CW'(DWELL - 1);
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                // Dropped request releases the bus even under hold.
                if (!req[se_q]) begin
                    state_d = GAP;
                    ptr_d   = se_q;
                end else if (hold) begin
                    cnt_d = cnt_q;
                end else if (cnt_q == '0) begin
                    state_d = GAP;
                    ptr_d   = se_q;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are computed from the next state and registered, so
    // nothing from req/hold reaches a port combinationally.
    always_comb begin
        en_d   = (state_d == GRANT);
        gs_d   = (state_d == GRANT) && (state_q != GRANT);
        busy_d = (state_d != IDLE);
    end

    assign se          = se_q;
    assign en          = en_q;
    assign grant_start = gs_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_mux_rr_sel.sv
// Bench for mux_rr_sel: two instances (DWELL=4 and DWELL=1) share
// stimulus; a per-cycle model plus literal checks cover both.
module tb_mux_rr_sel;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       hold = 1'b0;

    logic [1:0] se4, se1;
    logic       en4, en1, gs4, gs1, busy4, busy1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux_rr_sel #(.DWELL(4), .CW(8)) u_d4 (
        .clk(clk), .rst(rst), .req(req), .hold(hold),
        .se(se4), .en(en4), .grant_start(gs4), .busy(busy4)
    );

    mux_rr_sel #(.DWELL(1), .CW(8)) u_d1 (
        .clk(clk), .rst(rst), .req(req), .hold(hold),
        .se(se1), .en(en1), .grant_start(gs1), .busy(busy1)
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: index 0 is DWELL=4, index 1 is DWELL=1.
    int dw[2] = '{4, 1};
    bit m_on[2], m_gap[2], m_first[2];
    int m_ch[2], m_left[2], m_last[2];
    bit m_valid = 0;

    initial begin
        int pick;
        int c;
        forever begin
            @(posedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rst) begin
                    m_on[d] = 0; m_gap[d] = 0; m_first[d] = 0;
                    m_ch[d] = 0; m_left[d] = 0; m_last[d] = 3;
                    m_valid = 1;
                end else if (m_on[d]) begin
                    m_first[d] = 0;
                    if (!req[m_ch[d]] || (!hold && m_left[d] == 1)) begin
                        m_on[d] = 0;
                        m_gap[d] = 1;
                        m_last[d] = m_ch[d];
                    end else if (!hold) begin
                        m_left[d] = m_left[d] - 1;
                    end
                end else begin
                    pick = -1;
                    for (int k = 1; k <= 4; k++) begin
                        c = (m_last[d] + k) % 4;
                        if (pick < 0 && req[c]) pick = c;
                    end
                    m_gap[d] = 0;
                    m_first[d] = 0;
                    if (pick >= 0) begin
                        m_on[d] = 1;
                        m_ch[d] = pick;
                        m_left[d] = dw[d];
                        m_first[d] = 1;
                    end
                end
            end
            #1;
            if (m_valid) begin
                chk("se_d4", se4, m_ch[0]);
                chk("en_d4", en4, m_on[0]);
                chk("gs_d4", gs4, m_first[0]);
                chk("busy_d4", busy4, m_on[0] | m_gap[0]);
                chk("se_d1", se1, m_ch[1]);
                chk("en_d1", en1, m_on[1]);
                chk("gs_d1", gs1, m_first[1]);
                chk("busy_d1", busy1, m_on[1] | m_gap[1]);
            end
        end
    end

    // Reset for two cycles, then release with req=r; the next negedge
    // is the first cycle of the first possible grant.
    task automatic rst_seq(input logic [3:0] r);
        @(negedge clk);
        rst = 1'b1; req = 4'b0000; hold = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; req = r;
    endtask

    int en_p1[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    int gs_p1[10] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    int se_p2[5]  = '{0, 1, 2, 3, 0};
    int en_p6[5]  = '{1, 0, 1, 0, 1};
    int se_p6[5]  = '{0, 0, 2, 2, 0};
    int n;

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_en", en4, 0);
        chk("rst_se", se4, 0);
        chk("rst_busy", busy4, 0);
        chk("rst_gs", gs4, 0);

        // Single steady requester: 4 on, 1 gap
        rst_seq(4'b0001);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("p1_en", en4, en_p1[i]);
            chk("p1_gs", gs4, gs_p1[i]);
        end

        // All requesting: rotation 0,1,2,3,0
        rst_seq(4'b1111);
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            if (i % 5 == 0) chk("p2_se", se4, se_p2[i / 5]);
            if (i % 5 == 4) chk("p2_gap", en4, 0);
        end

        // Early release on channel 2, next goes to 3
        rst_seq(4'b0100);
        @(negedge clk);
        chk("p3_se", se4, 2);
        @(negedge clk);
        req = 4'b1000;
        @(negedge clk);
        chk("p3_rel_en", en4, 0);
        chk("p3_rel_busy", busy4, 1);
        @(negedge clk);
        chk("p3_next_se", se4, 3);
        chk("p3_next_en", en4, 1);

        // Early release on channel 2, only channel 0 left
        rst_seq(4'b0100);
        @(negedge clk);
        @(negedge clk);
        req = 4'b0001;
        @(negedge clk);
        chk("p3b_rel_en", en4, 0);
        @(negedge clk);
        chk("p3b_next_se", se4, 0);

        // Hold three cycles: 7 cycles of en
        rst_seq(4'b0001);
        @(negedge clk);
        n = en4;
        hold = 1'b1;
        for (int i = 2; i <= 8; i++) begin
            @(negedge clk);
            if (i == 4) hold = 1'b0;
            n += en4;
        end
        chk("p4_hold_len", n, 7);
        chk("p4_end_en", en4, 0);
        @(negedge clk);
        chk("p4_regrant", en4, 1);
        hold = 1'b1;
        req = 4'b0000;
        @(negedge clk);
        chk("p4_hold_rel", en4, 0);
        hold = 1'b0;

        // Reset mid-grant on channel 1
        rst_seq(4'b0010);
        @(negedge clk);
        chk("p5_se", se4, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("p5_rst_en", en4, 0);
        chk("p5_rst_se", se4, 0);
        chk("p5_rst_busy", busy4, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("p5_re_en", en4, 1);
        chk("p5_re_se", se4, 1);
        chk("p5_re_gs", gs4, 1);

        // DWELL=1 alternating single-cycle grants
        rst_seq(4'b0101);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("p6_en", en1, en_p6[i]);
            chk("p6_se", se1, se_p6[i]);
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
